// File: rtl/alu_pkg.sv
// Shared ALU-side constants and types, reused by the operand muxes and registers of each core.
package alu_pkg;

    localparam int ALU_WIDTH     = 16;
    localparam int ALU_SEL_W     = 2;
    localparam int ALU_NUM_SLOTS = 4;

    typedef logic [ALU_WIDTH-1:0] alu_word_t;
    typedef alu_word_t alu_slot_array_t [ALU_NUM_SLOTS];

endpackage : alu_pkg

// File: rtl/alu_mux_slot.sv
// One operand slot: a WIDTH-bit register with synchronous active-low reset and a load enable.
module alu_mux_slot
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] value_r;

    // Slot storage: clear on reset, otherwise load or hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            value_r <= {WIDTH{1'b0}};
        end else if (load) begin
            value_r <= d;
        end else begin
            value_r <= value_r;
        end
    end

    assign q = value_r;

endmodule : alu_mux_slot

// File: rtl/alu_mux.sv
// Registered 4-slot operand selector; writes pass straight through to data_out at the write edge.
module alu_mux
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SEL_W = ALU_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] select,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    localparam int NUM_SLOTS = 2 ** SEL_W;

    logic [WIDTH-1:0] slot_q_s [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] load_s;
    logic [WIDTH-1:0] next_out_s;
    logic [WIDTH-1:0] data_out_r;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign load_s[i] = enable && (select == SEL_W'(i));

        alu_mux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk  (clk),
            .rst  (rst),
            .load (load_s[i]),
            .d    (data_in),
            .q    (slot_q_s[i])
        );
    end

    // Output source: bypass the incoming write, else read the addressed slot.
    always_comb begin
        next_out_s = {WIDTH{1'b0}};
        if (enable) begin
            next_out_s = data_in;
        end else begin
            next_out_s = slot_q_s[select];
        end
    end

    // Output register presented to the ALU.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out_r <= {WIDTH{1'b0}};
        end else begin
            data_out_r <= next_out_s;
        end
    end

    assign data_out = data_out_r;

endmodule : alu_mux

// File: tb/tb_alu_mux.sv
// Self-checking bench for alu_mux: directed scenarios plus randomized traffic against a slot-array model.
module tb_alu_mux;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic [1:0]    select;
    logic          enable;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;

    int            n_checks;
    int            n_fail;

    // Reference model: four slots and the value expected on data_out.
    logic [W-1:0]  m_slot [4];
    logic [W-1:0]  m_out;

    alu_mux dut (
        .clk      (clk),
        .rst      (rst),
        .select   (select),
        .enable   (enable),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, take the edge, apply the rules to the model, then settle.
    task automatic tick(input logic r, input logic e, input logic [1:0] s, input logic [W-1:0] d);
        rst     = r;
        enable  = e;
        select  = s;
        data_in = d;
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 4; i++) m_slot[i] = '0;
            m_out = '0;
        end else if (e) begin
            m_slot[s] = d;
            m_out     = d;
        end else begin
            m_out = m_slot[s];
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 2'b00, 16'h0000);
            n_checks++;
            if (data_out !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset cycle %0d: data_out=%h expected=%h", i, data_out, 16'h0000);
            end
        end
    endtask

    task automatic test_sequential_writes();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 2'(i), 16'h3333);
            n_checks++;
            if (data_out !== 16'h3333) begin
                n_fail++;
                $display("FAIL seq_write slot %0d: data_out=%h expected=%h", i, data_out, 16'h3333);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            tick(1'b1, 1'b0, 2'(i), 16'hA5A5);
            n_checks++;
            if (data_out !== 16'h3333) begin
                n_fail++;
                $display("FAIL seq_read slot %0d: data_out=%h expected=%h", i, data_out, 16'h3333);
            end
        end
    endtask

    task automatic test_readback();
        logic [W-1:0] vals [4];
        logic [1:0]   order [3];
        logic [W-1:0] want [3];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h4444; vals[3] = 16'h8888;
        order[0] = 2'b11; order[1] = 2'b00; order[2] = 2'b10;
        want[0] = 16'h8888; want[1] = 16'h1111; want[2] = 16'h4444;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 2'(i), vals[i]);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, order[i], 16'h0000);
            n_checks++;
            if (data_out !== want[i]) begin
                n_fail++;
                $display("FAIL readback sel=%0d: data_out=%h expected=%h", order[i], data_out, want[i]);
            end
        end
    endtask

    task automatic test_bypass();
        tick(1'b1, 1'b1, 2'b10, 16'hBEEF);
        n_checks++;
        if (data_out !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL bypass write: data_out=%h expected=%h", data_out, 16'hBEEF);
        end
        tick(1'b1, 1'b0, 2'b10, 16'h0000);
        n_checks++;
        if (data_out !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL bypass readback: data_out=%h expected=%h", data_out, 16'hBEEF);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b1, 2'b01, 16'hFFFF);
        n_checks++;
        if (data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid: data_out=%h expected=%h", data_out, 16'h0000);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 2'(i), 16'hFFFF);
            n_checks++;
            if (data_out !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_mid read slot %0d: data_out=%h expected=%h", i, data_out, 16'h0000);
            end
        end
    endtask

    task automatic test_hold();
        logic [1:0] s;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 2'(i), 16'(16'h0F00 + 16'(i * 17)));
        for (int i = 0; i < 5; i++) begin
            s = 2'($urandom_range(0, 3));
            tick(1'b1, 1'b0, s, 16'($urandom));
            n_checks++;
            if (data_out !== 16'(16'h0F00 + 16'(int'(s) * 17))) begin
                n_fail++;
                $display("FAIL hold sel=%0d: data_out=%h expected=%h", s, data_out,
                         16'(16'h0F00 + 16'(int'(s) * 17)));
            end
        end
    endtask

    task automatic test_random();
        logic r;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 31) != 0);
            tick(r, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
            n_checks++;
            if (data_out !== m_out) begin
                n_fail++;
                $display("FAIL random cycle %0d: data_out=%h expected=%h", i, data_out, m_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 16'($urandom);
            tick(1'b1, 1'b1, 2'(i % 4), v);
            n_checks++;
            if (data_out !== v) begin
                n_fail++;
                $display("FAIL back_to_back write %0d: data_out=%h expected=%h", i, data_out, v);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 2'(i), 16'h0000);
            n_checks++;
            if (data_out !== m_out) begin
                n_fail++;
                $display("FAIL back_to_back read slot %0d: data_out=%h expected=%h", i, data_out, m_out);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        enable   = 1'b0;
        select   = 2'b00;
        data_in  = '0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        m_out = '0;
        #2;
        test_reset();
        test_sequential_writes();
        test_readback();
        test_bypass();
        test_reset_mid();
        test_hold();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_mux

// File: doc/alu_mux.md
# alu_mux

Registered 4-slot operand selector feeding one ALU input port in each core of the 8-core matrix-multiply processor. It holds four 16-bit operand values loaded from the data bus. It presents the slot addressed by `select` on `data_out` one clock after the request. Writes bypass straight to the output in the same cycle.

## Interface
Parameters:
- `WIDTH`, 16, data width of `data_in`, `data_out` and each slot.
- `SEL_W`, 2, select width; slot count is 2**SEL_W = 4.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst`, input, 1, reset; synchronous, active-low. `rst`=0 at a rising edge resets the block.
- `select`, input, SEL_W, slot address for both write and read.
- `enable`, input, 1, write strobe; 1 writes `data_in` into slot[`select`].
- `data_in`, input, WIDTH, operand value to load.
- `data_out`, output, WIDTH, registered operand presented to the ALU.

## Operation
- State: `slot[0..3]` (WIDTH bits each) and the `data_out` register.
- Reset (`rst`=0 at an edge):
  - all slots and `data_out` become 0;
  - `enable`, `select` and `data_in` are ignored.
- Normal edge (`rst`=1) with `enable`=1:
  - `slot[select]` <= `data_in`;
  - `data_out` <= `data_in` (write-through bypass, not the old slot content).
- Normal edge with `enable`=0:
  - slots unchanged;
  - `data_out` <= `slot[select]`.
- Each edge writes at most one slot. Unselected slots always hold.
- No arithmetic; values pass unmodified at full WIDTH, with no sign or zero extension.
- `select` is always in range (4 slots, 2 bits), so no out-of-range case exists.

## Timing
- Reset value: `data_out` = 0 and every slot = 0 from the first edge sampling `rst`=0. The value before the first reset edge is undefined.
- Read latency: 1 clock. `data_out` reflects the inputs sampled at the previous rising edge.
- Write latency: 1 clock. The slot and `data_out` both update at the same edge.
- Same-slot read after write:
  - a write at edge N, then `enable`=0 with the same `select` at edge N+1, gives `data_out` = the written value after N+1.
- Back-to-back writes to different slots: each edge updates its own slot. `data_out` tracks `data_in`.
- Reset mid-operation: it takes effect at the next edge and clears all slots. Reads after release return 0 until each slot is rewritten.
- Reset held for multiple cycles: the outputs stay 0. The first edge with `rst`=1 resumes normal operation.
- No handshake. `enable` is a single-cycle strobe that may stay high continuously (one write per cycle).

## Structure
- Shared package `alu_pkg`: `ALU_WIDTH`=16, `ALU_SEL_W`=2, `ALU_NUM_SLOTS`=4, and the slot-array typedef. This package is reused by the other ALU-side muxes and registers of each core.
- One natural sub-module, `alu_mux_slot`: a WIDTH-bit register with synchronous active-low reset and a load enable, instantiated 4 times.
- The read mux and output register stay in the top level.

## Test plan
- Power-up reset: `rst`=0 for 3 cycles, with `enable`=1, `select`=00, `data_in`=0x0000 -> `data_out`=0x0000 throughout.
- Sequential writes: `rst`=1, `enable`=1, `data_in`=0x3333, `select` stepping 00, 01, 10, 11 one cycle each -> `data_out`=0x3333 one cycle after each write; all four slots hold 0x3333.
- Readback: write 0x1111, 0x2222, 0x4444 and 0x8888 to slots 0-3, then `enable`=0 and `select`=11, 00, 10 -> `data_out`=0x8888, 0x1111, 0x4444, each one cycle after its `select`.
- Bypass: slot 2 holds 0x4444; write 0xBEEF to slot 2 -> `data_out`=0xBEEF at the write edge (not 0x4444); a following read of slot 2 still gives 0xBEEF.
- Reset mid-operation:
  - with slots loaded, drive `rst`=0 for one cycle while `enable`=1, `data_in`=0xFFFF -> `data_out`=0x0000 and no write occurs;
  - after release, reads of slots 0-3 with `enable`=0 -> 0x0000.
- Hold: `enable`=0 for 5 cycles with varying `data_in` -> no slot changes; `data_out` follows only `select`.
